// File: rtl/sram_fifo_ctrl.sv
// Ready/valid FIFO controller wrapped around a two-port SRAM macro with 1-cycle read latency.
// A 2-entry output buffer catches SRAM read data so the FIFO sustains one transfer per cycle.
module sram_fifo_ctrl #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_bits,
    output logic [ADDR_W+1:0] count,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_aa,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_reb,
    output logic [ADDR_W-1:0] sram_ab,
    input  logic [DATA_W-1:0] sram_q
);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              resp_valid;
    logic [DATA_W-1:0] obuf [2];
    logic              obuf_head;
    logic [1:0]        obuf_cnt;

    logic enq_fire;
    logic rd;
    logic obuf_has;
    logic obuf_pop;
    logic obuf_push;
    logic obuf_tail;

    assign obuf_has  = (obuf_cnt != 2'd0);
    assign enq_ready = (mem_cnt != (ADDR_W+1)'(DEPTH));

    // Reset and flush gate both SRAM strobes combinationally so the macro sees
    // no access while the controller state is being cleared.
    assign enq_fire = enq_valid & enq_ready & ~flush & ~reset;
    assign rd       = (mem_cnt != '0) & ((obuf_cnt + {1'b0, resp_valid}) < 2'd2)
                      & ~flush & ~reset;

    assign deq_valid = obuf_has | resp_valid;
    assign deq_bits  = obuf_has ? obuf[obuf_head] : sram_q;

    // SRAM data is parked in obuf unless the consumer takes it straight off the bypass.
    assign obuf_pop  = deq_valid & deq_ready & obuf_has;
    assign obuf_push = resp_valid & ~(~obuf_has & deq_ready);
    assign obuf_tail = obuf_head ^ obuf_cnt[0];

    assign count = (ADDR_W+2)'(mem_cnt) + (ADDR_W+2)'(resp_valid) + (ADDR_W+2)'(obuf_cnt);

    assign sram_web = ~enq_fire;
    assign sram_aa  = wptr;
    assign sram_d   = enq_bits;
    assign sram_reb = ~rd;
    assign sram_ab  = rptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            mem_cnt    <= '0;
            resp_valid <= 1'b0;
            obuf[0]    <= '0;
            obuf[1]    <= '0;
            obuf_head  <= 1'b0;
            obuf_cnt   <= 2'd0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            mem_cnt    <= '0;
            resp_valid <= 1'b0;
            obuf[0]    <= '0;
            obuf[1]    <= '0;
            obuf_head  <= 1'b0;
            obuf_cnt   <= 2'd0;
        end else begin
            if (enq_fire) wptr <= wptr + 1'b1;
            if (rd)       rptr <= rptr + 1'b1;
            if (enq_fire && !rd)
                mem_cnt <= mem_cnt + 1'b1;
            else if (!enq_fire && rd)
                mem_cnt <= mem_cnt - 1'b1;
            resp_valid <= rd;
            if (obuf_push) obuf[obuf_tail] <= sram_q;
            if (obuf_pop)  obuf_head <= ~obuf_head;
            obuf_cnt <= obuf_cnt - {1'b0, obuf_pop} + {1'b0, obuf_push};
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed and scoreboarded bench for sram_fifo_ctrl with a behavioural 16x128 SRAM beside it.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_sram_fifo_ctrl;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [DATA_W-1:0] enq_bits = '0;
    logic              deq_valid;
    logic              deq_ready = 1'b0;
    logic [DATA_W-1:0] deq_bits;
    logic [ADDR_W+1:0] count;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_aa;
    logic [DATA_W-1:0] sram_d;
    logic              sram_reb;
    logic [ADDR_W-1:0] sram_ab;
    logic [DATA_W-1:0] sram_q = '0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] sb [$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    sram_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (enq_bits),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_bits  (deq_bits),
        .count     (count),
        .sram_web  (sram_web),
        .sram_aa   (sram_aa),
        .sram_d    (sram_d),
        .sram_reb  (sram_reb),
        .sram_ab   (sram_ab),
        .sram_q    (sram_q)
    );

    // Read data is junk on cycles without a read, so any misuse of Q shows up as bad data.
    always @(posedge clock) begin
        if (!sram_web) mem[sram_aa] <= sram_d;
        if (!sram_reb) sram_q <= mem[sram_ab];
        else           sram_q <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic ev, input logic [127:0] eb, input logic dr, input logic fl);
        @(negedge clock);
        enq_valid = ev;
        enq_bits  = eb;
        deq_ready = dr;
        flush     = fl;
        #1;
        check("rw_conflict", {127'b0, (!sram_web && !sram_reb && sram_aa == sram_ab)}, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] a5  = {16{8'hA5}};
        logic [127:0] h3c = {16{8'h3C}};
        int  sent;
        int  cyc;

        // 1: reset values and first-word latency
        repeat (2) @(negedge clock);
        reset = 1'b0;
        drive(0, '0, 1, 0);
        check("rst_enq_ready", enq_ready, 1);
        check("rst_deq_valid", deq_valid, 0);
        check("rst_count",     count,     0);
        check("rst_web",       sram_web,  1);
        check("rst_reb",       sram_reb,  1);
        check("rst_aa",        sram_aa,   0);
        check("rst_ab",        sram_ab,   0);
        drive(1, a5, 1, 0);
        check("t0_web", sram_web, 0);
        check("t0_d",   sram_d,   a5);
        drive(0, '0, 1, 0);
        check("t1_reb",       sram_reb,  0);
        check("t1_deq_valid", deq_valid, 0);
        check("t1_count",     count,     1);
        drive(0, '0, 1, 0);
        check("t2_deq_valid", deq_valid, 1);
        check("t2_deq_bits",  deq_bits,  a5);
        drive(0, '0, 1, 0);
        check("t3_count",     count,     0);
        check("t3_deq_valid", deq_valid, 0);

        // 2: fill to DEPTH+2 with the consumer stalled, then drain in order
        for (int i = 0; i < 18; i++) begin
            drive(1, 128'(i), 0, 0);
            check("fill_enq_ready", enq_ready, 1);
        end
        drive(1, 128'(99), 0, 0);
        check("full_enq_ready", enq_ready, 0);
        check("full_web",       sram_web,  1);
        check("full_count",     count,     18);
        for (int i = 0; i < 18; i++) begin
            drive(0, '0, 1, 0);
            check("drain_valid", deq_valid, 1);
            check("drain_bits",  deq_bits,  128'(i));
        end
        drive(0, '0, 1, 0);
        check("drain_empty", deq_valid, 0);
        check("drain_count", count,     0);

        // 3: streaming, one word per cycle after a 2-cycle fill, pointers wrap
        for (int c = 0; c < 44; c++) begin
            drive(c < 40, 128'(32'h1000 + c), 1, 0);
            check("stream_valid", deq_valid, (c >= 2 && c < 42));
            if (c >= 2 && c < 42) check("stream_bits", deq_bits, 128'(32'h1000 + c - 2));
        end

        // 4: random traffic against a scoreboard
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
            drive(sent < 1000 && ($urandom % 4 != 0),
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom % 2, 0);
            check("rand_count", count, 128'(sb.size()));
            if (deq_valid && deq_ready) begin
                if (sb.size() == 0) check("rand_unexpected_deq", deq_valid, 0);
                else check("rand_bits", deq_bits, sb.pop_front());
            end
            if (enq_valid && enq_ready) begin
                sb.push_back(enq_bits);
                sent++;
            end
            cyc++;
        end
        check("rand_done", (sent == 1000 && sb.size() == 0), 1);

        // 5: flush with a read in flight and count=7
        for (int i = 0; i < 7; i++) drive(1, 128'(32'h200 + i), 0, 0);
        drive(0, '0, 1, 0);
        check("pre_flush_bits", deq_bits, 128'(32'h200));
        drive(1, 128'(32'h207), 0, 0);
        check("pre_flush_reb", sram_reb, 0);
        drive(1, 128'(32'h2FF), 1, 1);
        check("flush_count",     count,     7);
        check("flush_deq_valid", deq_valid, 1);
        check("flush_web",       sram_web,  1);
        check("flush_reb",       sram_reb,  1);
        drive(0, '0, 0, 0);
        check("post_flush_count", count,     0);
        check("post_flush_valid", deq_valid, 0);
        drive(1, h3c, 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        check("post_flush_valid2", deq_valid, 1);
        check("post_flush_bits",   deq_bits,  h3c);

        // 6: asynchronous reset in the middle of a stream
        for (int i = 0; i < 5; i++) drive(1, 128'(32'h500 + i), 1, 0);
        check("burst_web", sram_web, 0);
        check("burst_reb", sram_reb, 0);
        #1 reset = 1'b1;
        #1;
        check("arst_web",       sram_web,  1);
        check("arst_reb",       sram_reb,  1);
        check("arst_deq_valid", deq_valid, 0);
        check("arst_count",     count,     0);
        check("arst_enq_ready", enq_ready, 1);
        check("arst_aa",        sram_aa,   0);
        check("arst_ab",        sram_ab,   0);
        @(negedge clock);
        reset = 1'b0;
        drive(1, 128'(32'h77), 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        check("resume_valid", deq_valid, 1);
        check("resume_bits",  deq_bits,  128'(32'h77));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
